// File: rtl/poly_voice_mixer.sv
// Time-multiplexed N-voice mixer. Each accepted sample tick sweeps every voice
// through a registered-read port, scales oscillator by envelope, sums the
// products, then applies headroom shift, master gain and saturation.
module poly_voice_mixer #(
    parameter int NUM_VOICES     = 4,
    parameter int AMPLITUDE_BITS = 24,
    parameter int GAIN_BITS      = 16,
    parameter int HEADROOM_SHIFT = $clog2(NUM_VOICES),
    parameter int VA_BITS        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic [NUM_VOICES-1:0]     voice_mask,
    input  logic [GAIN_BITS-1:0]      master_gain,
    output logic [VA_BITS-1:0]        voice_addr,
    input  logic [AMPLITUDE_BITS-1:0] voice_osc,
    input  logic [AMPLITUDE_BITS-1:0] voice_env,
    output logic [AMPLITUDE_BITS-1:0] out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      clip,
    output logic                      overrun,
    input  logic                      overrun_clear
);

    // Accumulator wide enough for NUM_VOICES full-scale products plus a spare bit.
    localparam int ACC_W  = AMPLITUDE_BITS + VA_BITS + 1;
    localparam int PROD_W = 2 * AMPLITUDE_BITS;
    localparam int MUL_W  = ACC_W + GAIN_BITS;
    localparam int S_W    = ACC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_SCALE,
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [VA_BITS-1:0]        voice_addr_q, voice_addr_d;
    logic [NUM_VOICES-1:0]     mask_q, mask_d;
    logic [GAIN_BITS-1:0]      gain_q, gain_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      data_v_q, data_v_d;
    logic                      prod_v_q, prod_v_d;
    logic [AMPLITUDE_BITS-1:0] out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      clip_q, clip_d;
    logic                      overrun_q, overrun_d;

    logic [VA_BITS-1:0]        data_idx_q, data_idx_d;
    logic [AMPLITUDE_BITS-1:0] prod_q, prod_d;
    logic [S_W-1:0]            s_q, s_d;

    // Datapath: per-voice product and scaled sum, qualified by the valid flags.
    always_comb begin
        data_idx_d = voice_addr_q;
        prod_d     = '0;
        if (mask_q[data_idx_q]) begin
            prod_d = AMPLITUDE_BITS'((PROD_W'(voice_osc) * PROD_W'(voice_env)) >> AMPLITUDE_BITS);
        end
        s_d = S_W'((MUL_W'(acc_q >> HEADROOM_SHIFT) * MUL_W'(gain_q)) >> (GAIN_BITS - 1));
    end

    // Control: FSM next state, sweep counter, accumulator, result and flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        voice_addr_d = voice_addr_q;
        mask_d       = mask_q;
        gain_d       = gain_q;
        acc_d        = acc_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        clip_d       = 1'b0;
        data_v_d     = (state_q == S_FETCH);
        prod_v_d     = data_v_q;
        overrun_d    = overrun_q & ~overrun_clear;
        // A new overrun event outranks a same-cycle clear.
        if (sample_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
        if (prod_v_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d      = S_FETCH;
                    voice_addr_d = '0;
                    mask_d       = voice_mask;
                    gain_d       = master_gain;
                    acc_d        = '0;
                end
            end
            S_FETCH: begin
                if (voice_addr_q == VA_BITS'(NUM_VOICES - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    voice_addr_d = voice_addr_q + VA_BITS'(1);
                end
            end
            S_DRAIN: begin
                // Leave once the last product has been folded into the accumulator.
                if (!data_v_q && !prod_v_q) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                state_d     = S_OUTPUT;
                out_valid_d = 1'b1;
                if (s_q > S_W'({AMPLITUDE_BITS{1'b1}})) begin
                    out_d  = '1;
                    clip_d = 1'b1;
                end else begin
                    out_d = AMPLITUDE_BITS'(s_q);
                end
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset; a reset mid-mix aborts it.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= S_IDLE;
            voice_addr_q <= '0;
            mask_q       <= '0;
            gain_q       <= '0;
            acc_q        <= '0;
            data_v_q     <= 1'b0;
            prod_v_q     <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            voice_addr_q <= voice_addr_d;
            mask_q       <= mask_d;
            gain_q       <= gain_d;
            acc_q        <= acc_d;
            data_v_q     <= data_v_d;
            prod_v_q     <= prod_v_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
        end
    end

    // Datapath registers carry no reset.
    always_ff @(posedge clock) begin
        // NOTE: these are only consumed while their valid flag or FSM state says so, so no reset is needed.
        data_idx_q <= data_idx_d;
        prod_q     <= prod_d;
        s_q        <= s_d;
    end

    assign voice_addr = voice_addr_q;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign clip       = clip_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Self-checking bench for poly_voice_mixer: directed scenarios plus random mixes
// compared against an arithmetic reference model.
module tb_poly_voice_mixer;

    localparam int N  = 4;
    localparam int A  = 24;
    localparam int G  = 16;
    localparam int HS = 2;
    localparam int VA = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic [N-1:0]  voice_mask;
    logic [G-1:0]  master_gain;
    logic [VA-1:0] voice_addr;
    logic [A-1:0]  voice_osc;
    logic [A-1:0]  voice_env;
    logic [A-1:0]  out_s;
    logic          out_valid;
    logic          busy;
    logic          clip;
    logic          overrun;
    logic          overrun_clear;

    logic [A-1:0]  osc_mem [N];
    logic [A-1:0]  env_mem [N];

    int  passed = 0;
    int  total  = 0;
    bit  ovr_model = 1'b0;

    poly_voice_mixer #(
        .NUM_VOICES    (N),
        .AMPLITUDE_BITS(A),
        .GAIN_BITS     (G),
        .HEADROOM_SHIFT(HS),
        .VA_BITS       (VA)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .voice_mask   (voice_mask),
        .master_gain  (master_gain),
        .voice_addr   (voice_addr),
        .voice_osc    (voice_osc),
        .voice_env    (voice_env),
        .out          (out_s),
        .out_valid    (out_valid),
        .busy         (busy),
        .clip         (clip),
        .overrun      (overrun),
        .overrun_clear(overrun_clear)
    );

    always #5 clock = ~clock;

    // Voice store with a registered read port, one cycle of latency.
    always @(posedge clock) begin
        voice_osc <= osc_mem[voice_addr];
        voice_env <= env_mem[voice_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: sum of masked truncated products, headroom shift, Q1.15 gain, clamp.
    function automatic void model(input logic [N-1:0] m, input logic [G-1:0] g,
                                  output logic [A-1:0] o, output logic c);
        longint unsigned sum = 0;
        longint unsigned s;
        longint unsigned max_v = (64'd1 << A) - 1;
        for (int k = 0; k < N; k++) begin
            if (m[k]) sum += (longint'(osc_mem[k]) * longint'(env_mem[k])) >> A;
        end
        s = ((sum >> HS) * longint'(g)) >> (G - 1);
        c = (s > max_v);
        o = c ? A'(max_v) : A'(s);
    endfunction

    task automatic fill(input bit full_scale);
        for (int k = 0; k < N; k++) begin
            osc_mem[k] = full_scale ? {A{1'b1}} : A'($urandom);
            env_mem[k] = full_scale ? {A{1'b1}} : A'($urandom);
        end
    endtask

    // One mix starting at a negedge (cycle T); cycle T+c is checked at its negedge.
    // Optional events at cycle T+c: second tick, overrun_clear, input change, reset.
    task automatic run_mix(input logic [N-1:0] m, input logic [G-1:0] g,
                           input int tick2_at, input int clr_at, input int chg_at,
                           input int rst_at, input string tag);
        logic [A-1:0] e_out;
        logic         e_clip;
        bit           aborted;
        bit           busy_exp;
        model(m, g, e_out, e_clip);
        voice_mask  = m;
        master_gain = g;
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        for (int c = 1; c <= N + 6; c++) begin
            aborted  = (rst_at > 0) && (c > rst_at);
            busy_exp = !aborted && (c <= N + 5);
            if (aborted) begin
                check($sformatf("%s c%0d abort busy", tag, c), 64'(busy), 64'(0));
                check($sformatf("%s c%0d abort valid", tag, c), 64'(out_valid), 64'(0));
                check($sformatf("%s c%0d abort out", tag, c), 64'(out_s), 64'(0));
            end else begin
                check($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'(busy_exp));
                check($sformatf("%s c%0d valid", tag, c), 64'(out_valid), 64'(c == N + 5));
                check($sformatf("%s c%0d addr", tag, c), 64'(voice_addr),
                      64'((c <= N) ? c - 1 : N - 1));
                if (c >= N + 5) check($sformatf("%s c%0d out", tag, c), 64'(out_s), 64'(e_out));
                if (c == N + 5) check($sformatf("%s clip", tag), 64'(clip), 64'(e_clip));
            end
            check($sformatf("%s c%0d overrun", tag, c), 64'(overrun), 64'(ovr_model));
            if (c == tick2_at) sample_tick = 1'b1;
            if (c == clr_at)   overrun_clear = 1'b1;
            if (c == chg_at) begin
                voice_mask  = ~m;
                master_gain = ~g;
            end
            if (c == rst_at)   reset = 1'b1;
            @(negedge clock);
            if (reset)                         ovr_model = 1'b0;
            else if (sample_tick && busy_exp)  ovr_model = 1'b1;
            else if (overrun_clear)            ovr_model = 1'b0;
            sample_tick   = 1'b0;
            overrun_clear = 1'b0;
            reset         = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        sample_tick   = 1'b0;
        overrun_clear = 1'b0;
        voice_mask    = '0;
        master_gain   = '0;
        fill(1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset out", 64'(out_s), 64'(0));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset clip", 64'(clip), 64'(0));
        check("reset overrun", 64'(overrun), 64'(0));
        check("reset addr", 64'(voice_addr), 64'(0));

        // Single full-scale voice at unity gain.
        run_mix(4'b0001, 16'h8000, 0, 0, 0, 0, "one_voice");
        // All voices full scale: just under max at unity, clipped at ~2x.
        run_mix(4'b1111, 16'h8000, 0, 0, 0, 0, "all_unity");
        run_mix(4'b1111, 16'hFFFF, 0, 0, 0, 0, "all_clip");
        // Empty mask still sweeps the addresses and yields zero.
        fill(1'b0);
        run_mix(4'b0000, 16'hFFFF, 0, 0, 0, 0, "no_voice");

        // Second tick while busy: overrun set, mix unaffected, then cleared.
        run_mix(4'b1011, 16'h8000, 3, 0, 0, 0, "overrun");
        overrun_clear = 1'b1;
        @(negedge clock);
        overrun_clear = 1'b0;
        ovr_model     = 1'b0;
        check("overrun cleared", 64'(overrun), 64'(0));

        // Clear and new overrun in the same cycle: set wins.
        run_mix(4'b0110, 16'h4000, 2, 2, 0, 0, "set_wins");
        run_mix(4'b0110, 16'h4000, 0, 1, 0, 0, "clear_in_mix");

        // Reset mid-mix aborts without a result; a following mix is normal.
        run_mix(4'b1111, 16'h8000, 0, 0, 0, 4, "abort");
        run_mix(4'b1101, 16'hC000, 0, 0, 0, 0, "after_abort");

        // Mask/gain changes during a mix are ignored.
        fill(1'b1);
        run_mix(4'b0001, 16'h8000, 0, 0, 2, 0, "late_change");

        // Random mixes.
        for (int i = 0; i < 12; i++) begin
            fill(1'b0);
            run_mix(N'($urandom), G'($urandom), 0, 0, 0, 0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
